vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and types for the VGA raster timing generator.
// Provides 640x480@60 timing constants, derived totals, the per-axis
// decode payload, and a helper that returns the minimum counter width.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Bits needed to hold total-1 (at least one bit).
  function automatic int unsigned min_cnt_w(input int unsigned total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  localparam int unsigned DEF_CNT_W =
    min_cnt_w((DEF_H_TOTAL > DEF_V_TOTAL) ? DEF_H_TOTAL : DEF_V_TOTAL);

  // Registered per-axis decode: sync at output polarity, blank when outside active.
  typedef struct packed {
    logic sync;
    logic blank;
  } axis_decode_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync/blank decode.
// Ports: clk, rst_n (async active-low), advance (step the counter this cycle),
//        count (registered position), wrap_c (count is at TOTAL-1),
//        active_nxt_c (active-region flag of the value being loaded),
//        decode (registered sync/blank describing count).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c,
  output logic             active_nxt_c,
  output axis_decode_t     decode
);

  localparam int unsigned      TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  // Reset parks the counter at TOTAL-1, which lies in the back porch.
  localparam axis_decode_t RST_DECODE = '{sync: ~POL, blank: 1'b1};

  logic [CNT_W-1:0] count_q, count_d, count_inc;
  axis_decode_t     decode_q, decode_d;

  // Next count and decode of that next count, so decode lands with the count.
  always_comb begin
    wrap_c         = (count_q == LAST);
    count_inc      = wrap_c ? '0 : count_q + CNT_W'(1);
    count_d        = advance ? count_inc : count_q;
    active_nxt_c   = (count_d < ACT_END);
    decode_d.blank = ~active_nxt_c;
    decode_d.sync  = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= LAST;
      decode_q <= RST_DECODE;
    end else begin
      count_q  <= count_d;
      decode_q <= decode_d;
    end
  end

  assign count  = count_q;
  assign decode = decode_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Ports: VGA_clk, VGA_rst_n (async active-low), VGA_ce (pixel enable);
//        xCount/yCount, displayArea, VGA_hSync/VGA_vSync, hBlank/vBlank,
//        line_start/frame_start strobes -- all registered and aligned.
// Optional macro VGA_LOOKAHEAD_EN adds combinational next_xCount,
// next_yCount and next_displayArea (values after the next enabled update).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             VGA_clk,
  input  logic             VGA_rst_n,
  input  logic             VGA_ce,
  output logic [CNT_W-1:0] xCount,
  output logic [CNT_W-1:0] yCount,
  output logic             displayArea,
  output logic             VGA_hSync,
  output logic             VGA_vSync,
  output logic             hBlank,
  output logic             vBlank,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0] next_xCount,
  output logic [CNT_W-1:0] next_yCount,
  output logic             next_displayArea
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CNT_SPAN = 1 << CNT_W;

  // Reject configurations the counters cannot represent.
  if ((H_TOTAL > CNT_SPAN) || (V_TOTAL > CNT_SPAN) ||
      (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_cfg_err
    $error("vga_timing_gen: zero timing parameter or total exceeds 2**CNT_W");
  end

  logic         h_wrap_c, v_wrap_c;
  logic         h_active_nxt_c, v_active_nxt_c;
  axis_decode_t h_dec, v_dec;

  logic display_area_q, display_area_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk          (VGA_clk),
    .rst_n        (VGA_rst_n),
    .advance      (VGA_ce),
    .count        (xCount),
    .wrap_c       (h_wrap_c),
    .active_nxt_c (h_active_nxt_c),
    .decode       (h_dec)
  );

  // Lines advance only on the pixel update that wraps the column counter.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk          (VGA_clk),
    .rst_n        (VGA_rst_n),
    .advance      (VGA_ce & h_wrap_c),
    .count        (yCount),
    .wrap_c       (v_wrap_c),
    .active_nxt_c (v_active_nxt_c),
    .decode       (v_dec)
  );

  // Composite flags computed from the counters' next values.
  always_comb begin
    display_area_d = h_active_nxt_c & v_active_nxt_c;
    line_start_d   = VGA_ce & h_wrap_c;
    frame_start_d  = line_start_d & v_wrap_c;
  end

  always_ff @(posedge VGA_clk or negedge VGA_rst_n) begin
    if (!VGA_rst_n) begin
      display_area_q <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      display_area_q <= display_area_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign displayArea = display_area_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign VGA_hSync   = h_dec.sync;
  assign VGA_vSync   = v_dec.sync;
  assign hBlank      = h_dec.blank;
  assign vBlank      = v_dec.blank;

`ifdef VGA_LOOKAHEAD_EN
  // Position after the next enabled update, independent of VGA_ce.
  always_comb begin
    next_xCount = h_wrap_c ? '0 : xCount + CNT_W'(1);
    next_yCount = yCount;
    if (h_wrap_c) begin
      next_yCount = v_wrap_c ? '0 : yCount + CNT_W'(1);
    end
    next_displayArea = (next_xCount < CNT_W'(H_ACTIVE)) && (next_yCount < CNT_W'(V_ACTIVE));
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance (A) and a small
// 16x7 instance (B). Reference model tracks a linear pixel index per frame.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic de, hs, vs, hb, vb, ls, fs;
  } obs_t;

  typedef struct {
    int unsigned ha, hf, hs, hbp, va, vf, vs, vbp;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int unsigned ncyc;
    bit          ce;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, ce_a, rst_b, ce_b;

  logic [9:0] xa, ya;
  logic dea, hsa, vsa, hba, vba, lsa, fsa;
  logic [3:0] xb, yb;
  logic deb, hsb, vsb, hbb, vbb, lsb, fsb;
`ifdef VGA_LOOKAHEAD_EN
  logic [9:0] nxa, nya;
  logic       nda;
  logic [3:0] nxb, nyb;
  logic       ndb;
`endif

  vga_timing_gen u_dut_a (
    .VGA_clk     (clk),
    .VGA_rst_n   (rst_a),
    .VGA_ce      (ce_a),
    .xCount      (xa),
    .yCount      (ya),
    .displayArea (dea),
    .VGA_hSync   (hsa),
    .VGA_vSync   (vsa),
    .hBlank      (hba),
    .vBlank      (vba),
    .line_start  (lsa),
    .frame_start (fsa)
`ifdef VGA_LOOKAHEAD_EN
    ,
    .next_xCount      (nxa),
    .next_yCount      (nya),
    .next_displayArea (nda)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(4)
  ) u_dut_b (
    .VGA_clk     (clk),
    .VGA_rst_n   (rst_b),
    .VGA_ce      (ce_b),
    .xCount      (xb),
    .yCount      (yb),
    .displayArea (deb),
    .VGA_hSync   (hsb),
    .VGA_vSync   (vsb),
    .hBlank      (hbb),
    .vBlank      (vbb),
    .line_start  (lsb),
    .frame_start (fsb)
`ifdef VGA_LOOKAHEAD_EN
    ,
    .next_xCount      (nxb),
    .next_yCount      (nyb),
    .next_displayArea (ndb)
`endif
  );

  cfg_t        cfg [2];
  int unsigned pos [2];
  bit          mls [2];
  bit          mfs [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int unsigned ht(input cfg_t c);
    return c.ha + c.hf + c.hs + c.hbp;
  endfunction

  function automatic int unsigned ftotal(input cfg_t c);
    return ht(c) * (c.va + c.vf + c.vs + c.vbp);
  endfunction

  function automatic obs_t mk(input int unsigned x, input int unsigned y,
                              input bit de, input bit hs, input bit vs, input bit hb,
                              input bit vb, input bit ls, input bit fs);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y);
    o.de = de; o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Expected outputs straight from the raster rules for pixel index p.
  function automatic obs_t expect_obs(input cfg_t c, input int unsigned p, input bit ls, input bit fs);
    int unsigned x, y;
    bit hs_on, vs_on;
    x = p % ht(c);
    y = p / ht(c);
    hs_on = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
    vs_on = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
    return mk(x, y, (x < c.ha) && (y < c.va), hs_on ? c.hpol : !c.hpol,
              vs_on ? c.vpol : !c.vpol, x >= c.ha, y >= c.va, ls, fs);
  endfunction

  function automatic obs_t actual(input int d);
    if (d == 0) return mk(xa, ya, dea, hsa, vsa, hba, vba, lsa, fsa);
    return mk(10'(xb), 10'(yb), deb, hsb, vsb, hbb, vbb, lsb, fsb);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got x=%0d y=%0d de=%b hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b ; need x=%0d y=%0d de=%b hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b",
               name, $time, act.x, act.y, act.de, act.hs, act.vs, act.hb, act.vb, act.ls, act.fs,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.hb, exp.vb, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    pos[d] = ftotal(cfg[d]) - 1;
    mls[d] = 1'b0;
    mfs[d] = 1'b0;
  endtask

  // One clock on instance d with the given enable, then model step and compare.
  task automatic tick(input int d, input bit ce, input string name);
    if (d == 0) ce_a = ce; else ce_b = ce;
    @(posedge clk);
    if (ce) begin
      pos[d] = (pos[d] + 1) % ftotal(cfg[d]);
      mls[d] = (pos[d] % ht(cfg[d])) == 0;
      mfs[d] = (pos[d] == 0);
    end else begin
      mls[d] = 1'b0;
      mfs[d] = 1'b0;
    end
    #1;
    check(name, actual(d), expect_obs(cfg[d], pos[d], mls[d], mfs[d]));
`ifdef VGA_LOOKAHEAD_EN
    if (d == 0) begin
      obs_t nx;
      nx = expect_obs(cfg[0], (pos[0] + 1) % ftotal(cfg[0]), 1'b0, 1'b0);
      check_int("lookahead_a", int'({nxa, nya, nda}), int'({nx.x, nx.y, nx.de}));
    end
`endif
  endtask

  vec_t vecs [15];

  initial begin
    int fall_x, hs_low, per;
    logic de_prev;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1'b0};

    // Directed walk through instance B from reset: {cycles, ce, expected}.
    vecs[0]  = '{1,  1'b1, mk(0,  0, 1, 0, 1, 0, 0, 1, 1)};
    vecs[1]  = '{1,  1'b0, mk(0,  0, 1, 0, 1, 0, 0, 0, 0)};
    vecs[2]  = '{1,  1'b1, mk(1,  0, 1, 0, 1, 0, 0, 0, 0)};
    vecs[3]  = '{7,  1'b1, mk(8,  0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[4]  = '{2,  1'b1, mk(10, 0, 0, 1, 1, 1, 0, 0, 0)};
    vecs[5]  = '{2,  1'b1, mk(12, 0, 0, 1, 1, 1, 0, 0, 0)};
    vecs[6]  = '{1,  1'b1, mk(13, 0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[7]  = '{2,  1'b1, mk(15, 0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[8]  = '{1,  1'b1, mk(0,  1, 1, 0, 1, 0, 0, 1, 0)};
    vecs[9]  = '{1,  1'b0, mk(0,  1, 1, 0, 1, 0, 0, 0, 0)};
    vecs[10] = '{64, 1'b1, mk(0,  5, 0, 0, 0, 0, 1, 1, 0)};
    vecs[11] = '{15, 1'b1, mk(15, 5, 0, 0, 0, 1, 1, 0, 0)};
    vecs[12] = '{1,  1'b1, mk(0,  6, 0, 0, 1, 0, 1, 1, 0)};
    vecs[13] = '{15, 1'b1, mk(15, 6, 0, 0, 1, 1, 1, 0, 0)};
    vecs[14] = '{1,  1'b1, mk(0,  0, 1, 0, 1, 0, 0, 1, 1)};

    rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b1; ce_b = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", actual(0), expect_obs(cfg[0], pos[0], 1'b0, 1'b0));
    check("reset_b", actual(1), expect_obs(cfg[1], pos[1], 1'b0, 1'b0));
    ce_b = 1'b0;

    // Instance A: release, run to column 300, then async reset mid-line.
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 301; i++) tick(0, 1'b1, "run_a");
    check_int("x_at_300", int'(xa), 300);
    #2 rst_a = 1'b0;
    model_reset(0);
    #1;
    check("async_reset_a", actual(0), expect_obs(cfg[0], pos[0], 1'b0, 1'b0));
    #1 rst_a = 1'b1;

    // Restart and sweep two lines: display fall column and hsync width.
    fall_x = -1; hs_low = 0; de_prev = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      tick(0, 1'b1, "line_a");
      if ((pos[0] / ht(cfg[0])) == 0 && de_prev && !dea && fall_x < 0) fall_x = int'(xa);
      if ((pos[0] / ht(cfg[0])) == 1 && !hsa) hs_low++;
      de_prev = dea;
    end
    check_int("de_fall_x", fall_x, 640);
    check_int("hsync_width", hs_low, 96);

    for (int i = 0; i < 1000; i++) tick(0, 1'($urandom_range(0, 1)), "rand_a");
    ce_a = 1'b0;

    // Instance B: table walk from reset.
    @(negedge clk);
    rst_b = 1'b1;
    for (int v = 0; v < 15; v++) begin
      for (int c = 0; c < int'(vecs[v].ncyc); c++) tick(1, vecs[v].ce, "walk_b");
      check($sformatf("vec%0d", v), actual(1), vecs[v].exp);
    end

    // Frame period with ce always high, then with ce every other clock.
    per = 0;
    for (int i = 1; i <= 500; i++) begin
      tick(1, 1'b1, "period1_b");
      if (fsb) begin per = i; break; end
    end
    check_int("frame_period_ce1", per, 112);
    per = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick(1, 1'(i % 2 == 0), "period2_b");
      if (fsb) begin per = i; break; end
    end
    check_int("frame_period_ce2", per, 224);

    for (int i = 0; i < 600; i++) tick(1, 1'($urandom_range(0, 1)), "rand_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
